// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames and
// buffers valid scan codes in a show-ahead FIFO read by edge-detected ps2_rd.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ps2_rd,
    output logic [7:0]  key,
    output logic        ps2_ready,
    output logic        overflow,
    output logic        frame_err,
    output logic [31:0] key_d
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          rd_q, rd_prev_q;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   key_d_q, key_d_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fe, frame_valid, empty, full, do_pop, do_push;

    assign fe = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        frame_valid = 1'b0;
        frame_err_d = 1'b0;
        tmo_d       = (state_q == StIdle || fe) ? '0 : tmo_q + 1'b1;
        if (fe) begin
            case (state_q)
                StIdle: begin
                    if (!dat_s2_q) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d  = {dat_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = dat_s2_q;
                    state_d  = StStop;
                end
                default: begin
                    if (dat_s2_q && (^shreg_q ^ parity_q)) frame_valid = 1'b1;
                    else                                   frame_err_d = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end else if (state_q != StIdle && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Line stalled mid-frame: drop the partial byte.
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = rd_q & ~rd_prev_q & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push  = frame_valid & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (do_pop)                      overflow_d = 1'b0;
        else if (frame_valid && !do_push) overflow_d = 1'b1;
        else                             overflow_d = overflow_q;
        key_d_d  = frame_valid ? {key_d_q[23:0], shreg_q} : key_d_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            rd_q        <= 1'b0;
            rd_prev_q   <= 1'b0;
            state_q     <= StIdle;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            key_d_q     <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            rd_q        <= ps2_rd;
            rd_prev_q   <= rd_q;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            key_d_q     <= key_d_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
    end

    assign key       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign ps2_ready = ~empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign key_d     = key_d_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized frames
// compared against a queue-based model of the scan-code buffer.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 5000;
    localparam int          HALF  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ps2_rd = 1'b0;
    logic [7:0]  key;
    logic        ps2_ready, overflow, frame_err;
    logic [31:0] key_d;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err = 0;

    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_keyd = 32'h0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_rd(ps2_rd),
        .key(key), .ps2_ready(ps2_ready), .overflow(overflow), .frame_err(frame_err),
        .key_d(key_d)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_key();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    function automatic logic m_ready();
        return q.size() > 0;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad, input bit rd_at_stop);
        if (rd_at_stop && q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
        if (bad) exp_err++;
        else begin
            m_keyd = {m_keyd[23:0], b};
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit rd_at_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (rd_at_last && i == n - 1) begin
                // Rising read lines up with the stop-bit push inside the DUT.
                @(negedge clk);
                ps2_rd = 1'b1;
                repeat (HALF - 1) @(negedge clk);
                ps2_rd = 1'b0;
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rd_at_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11, rd_at_stop);
        model_frame(b, bad_par | bad_stop, rd_at_stop);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rd(input int hold);
        @(negedge clk);
        ps2_rd = 1'b1;
        repeat (hold) @(negedge clk);
        ps2_rd = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        m_ovf = 1'b0;
        m_keyd = 32'h0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h exp 00", key); end
        checks++; if (ps2_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ps2_ready); end
        checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b ferr=%b exp 0 0", overflow, frame_err);
        end
        checks++; if (key_d !== 32'h0) begin errors++; $display("FAIL reset_keyd: got %h exp 0", key_d); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++; if (key !== 8'h1C || key !== m_key()) begin errors++; $display("FAIL single_key: got %h exp %h", key, m_key()); end
        checks++; if (ps2_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", ps2_ready); end
        checks++; if (key_d !== 32'h0000001C) begin errors++; $display("FAIL single_keyd: got %h exp 0000001c", key_d); end
        checks++; if (err_seen !== exp_err) begin errors++; $display("FAIL single_ferr: got %0d exp %0d", err_seen, exp_err); end
    endtask

    task automatic test_hold_read();
        apply_reset();
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        pulse_rd(10);
        checks++; if (key !== m_key() || key !== 8'h1C) begin errors++; $display("FAIL hold_key: got %h exp %h", key, m_key()); end
        checks++; if (ps2_ready !== m_ready()) begin errors++; $display("FAIL hold_ready: got %b exp %b", ps2_ready, m_ready()); end
        pulse_rd(1);
        checks++; if (ps2_ready !== 1'b0 || key !== 8'h00) begin
            errors++; $display("FAIL hold_empty: got ready=%b key=%h exp 0 00", ps2_ready, key);
        end
        pulse_rd(1);
        checks++; if (ps2_ready !== 1'b0 || key !== 8'h00) begin
            errors++; $display("FAIL pop_empty: got ready=%b key=%h exp 0 00", ps2_ready, key);
        end
        checks++; if (key_d !== m_keyd || key_d !== 32'h0000F01C) begin
            errors++; $display("FAIL hold_keyd: got %h exp %h", key_d, m_keyd);
        end
    endtask

    task automatic test_bad_frames();
        apply_reset();
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        checks++; if (err_seen !== exp_err) begin errors++; $display("FAIL parity_ferr: got %0d exp %0d", err_seen, exp_err); end
        checks++; if (ps2_ready !== 1'b0 || key_d !== m_keyd) begin
            errors++; $display("FAIL parity_state: got ready=%b keyd=%h exp 0 %h", ps2_ready, key_d, m_keyd);
        end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (err_seen !== exp_err) begin errors++; $display("FAIL stop_ferr: got %0d exp %0d", err_seen, exp_err); end
        checks++; if (ps2_ready !== 1'b0 || key_d !== m_keyd) begin
            errors++; $display("FAIL stop_state: got ready=%b keyd=%h exp 0 %h", ps2_ready, key_d, m_keyd);
        end
    endtask

    task automatic test_timeout();
        int n;
        int expect_n;
        bit seen;
        apply_reset();
        send_bits(11'b000_0000_1000, 4, 1'b0);
        // Count negedges from here until the abort pulse appears.
        expect_n = TMO + 2 - HALF;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= TMO + 100; i++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        exp_err++;
        checks++; if (!seen || n < expect_n - 3 || n > expect_n + 3) begin
            errors++; $display("FAIL timeout_delay: got seen=%b cycles=%0d exp ~%0d", seen, n, expect_n);
        end
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b exp 0", frame_err); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        checks++; if (key !== 8'h5A || ps2_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_next: got key=%h ready=%b exp 5a 1", key, ps2_ready);
        end
        checks++; if (err_seen !== exp_err) begin errors++; $display("FAIL timeout_ferr: got %0d exp %0d", err_seen, exp_err); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== m_ovf || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b exp %b", overflow, m_ovf);
        end
        checks++; if (key !== m_key() || key_d !== 32'h06070809) begin
            errors++; $display("FAIL ovf_data: got key=%h keyd=%h exp %h 06070809", key, key_d, m_key());
        end
        pulse_rd(1);
        checks++; if (overflow !== 1'b0 || key !== 8'h02) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b key=%h exp 0 02", overflow, key);
        end
    endtask

    task automatic test_simultaneous();
        send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
        checks++; if (q.size() != DEPTH) begin errors++; $display("FAIL sim_fill: got %0d exp %0d", q.size(), DEPTH); end
        send_frame(8'h0B, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0 || key !== m_key()) begin
            errors++; $display("FAIL sim_push: got ovf=%b key=%h exp 0 %h", overflow, key, m_key());
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (ps2_ready !== 1'b1 || key !== m_key()) begin
                errors++; $display("FAIL sim_drain%0d: got ready=%b key=%h exp 1 %h", i, ps2_ready, key, m_key());
            end
            pulse_rd(1);
        end
        checks++; if (ps2_ready !== 1'b0) begin errors++; $display("FAIL sim_count: got ready=%b exp 0", ps2_ready); end
    endtask

    task automatic test_async_reset();
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_bits(11'b000_1010_1010, 5, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (key !== 8'h00 || ps2_ready !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0 ||
                      key_d !== 32'h0) begin
            errors++; $display("FAIL async_reset: got key=%h rdy=%b ovf=%b ferr=%b keyd=%h exp all 0",
                               key, ps2_ready, overflow, frame_err, key_d);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_keyd = 32'h0;
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        checks++; if (key !== 8'h5A || key_d !== 32'h0000005A) begin
            errors++; $display("FAIL post_reset: got key=%h keyd=%h exp 5a 0000005a", key, key_d);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            r = $urandom_range(0, 9);
            send_frame(b, r == 0, r == 1, 1'b0);
            checks++; if (key !== m_key() || ps2_ready !== m_ready() || overflow !== m_ovf ||
                          key_d !== m_keyd || err_seen !== exp_err) begin
                errors++; $display("FAIL rand%0d: got key=%h rdy=%b ovf=%b keyd=%h ferr=%0d exp %h %b %b %h %0d",
                                   i, key, ps2_ready, overflow, key_d, err_seen,
                                   m_key(), m_ready(), m_ovf, m_keyd, exp_err);
            end
            if ($urandom_range(0, 2) == 0) pulse_rd($urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hold_read();
        test_bad_frames();
        test_timeout();
        test_overflow();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
